// File: rtl/alu_pkg.sv
// Shared constants and types for the execute-stage ALU and branch unit.
package alu_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned SHAMT_W = 6;

    // Operation class from main control.
    localparam logic [1:0] AluOpMem    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpRtype  = 2'b10;
    localparam logic [1:0] AluOpItype  = 2'b11;

    // Decoded ALU operation codes.
    typedef enum logic [3:0] {
        AluAnd  = 4'b0000,
        AluOr   = 4'b0001,
        AluAdd  = 4'b0010,
        AluXor  = 4'b0011,
        AluSll  = 4'b0100,
        AluSrl  = 4'b0101,
        AluSub  = 4'b0110,
        AluSra  = 4'b0111,
        AluSlt  = 4'b1000,
        AluSltu = 4'b1001
    } alu_ctl_e;

    // funct3 values of the integer ALU instructions.
    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3Sll    = 3'b001;
    localparam logic [2:0] F3Slt    = 3'b010;
    localparam logic [2:0] F3Sltu   = 3'b011;
    localparam logic [2:0] F3Xor    = 3'b100;
    localparam logic [2:0] F3Shr    = 3'b101;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3And    = 3'b111;

    // funct3 values of the conditional branches.
    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Integer ALU: operation select on decoded alu_control plus result/compare flags.
module alu_core #(
    parameter int unsigned XLEN    = alu_pkg::XLEN,
    parameter int unsigned SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y,
    output logic            zero,
    output logic            s_less,
    output logic            u_less
);
    import alu_pkg::*;

    logic [SHAMT_W-1:0] shamt;

    assign shamt  = b[SHAMT_W-1:0];
    // Compare flags are always live; the branch judge relies on them regardless of op.
    assign s_less = $signed(a) < $signed(b);
    assign u_less = a < b;
    assign zero   = (y == '0);

    // Result mux; unlisted codes produce zero.
    always_comb begin
        y = '0;
        case (alu_control)
            AluAnd:  y = a & b;
            AluOr:   y = a | b;
            AluAdd:  y = a + b;
            AluXor:  y = a ^ b;
            AluSll:  y = a << shamt;
            AluSrl:  y = a >> shamt;
            AluSub:  y = a - b;
            AluSra:  y = $unsigned($signed(a) >>> shamt);
            AluSlt:  y = {{(XLEN-1){1'b0}}, s_less};
            AluSltu: y = {{(XLEN-1){1'b0}}, u_less};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_branch_unit.sv
// Execute-stage block: ALU decode, integer ALU, branch decision and a registered
// copy of the branch outcome for trace.
module alu_branch_unit #(
    parameter int unsigned XLEN    = alu_pkg::XLEN,
    parameter int unsigned SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      alu_op,
    input  logic [2:0]      funct3,
    input  logic            funct7_b5,
    input  logic            branch,
    input  logic [XLEN-1:0] a1,
    input  logic [XLEN-1:0] a2,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] y,
    output logic            zero,
    output logic            s_less,
    output logic            u_less,
    output logic            branch_taken,
    output logic            branch_taken_q
);
    import alu_pkg::*;

    alu_ctl_e ctl;
    logic     cond;

    // Decode operation class and funct fields into an ALU operation.
    always_comb begin
        ctl = AluAdd;
        if (alu_op == AluOpMem) begin
            ctl = AluAdd;
        end else if (alu_op == AluOpBranch) begin
            ctl = AluSub;
        end else begin
            case (funct3)
                // I-type carries immediate bits in funct7, so only R-type may subtract.
                F3AddSub: ctl = (alu_op == AluOpRtype && funct7_b5) ? AluSub : AluAdd;
                F3Sll:    ctl = AluSll;
                F3Slt:    ctl = AluSlt;
                F3Sltu:   ctl = AluSltu;
                F3Xor:    ctl = AluXor;
                F3Shr:    ctl = funct7_b5 ? AluSra : AluSrl;
                F3Or:     ctl = AluOr;
                F3And:    ctl = AluAnd;
                default:  ctl = AluAdd;
            endcase
        end
    end

    assign alu_control = ctl;

    alu_core #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_alu_core (
        .alu_control (alu_control),
        .a           (a1),
        .b           (a2),
        .y           (y),
        .zero        (zero),
        .s_less      (s_less),
        .u_less      (u_less)
    );

    // Branch condition from funct3 and the ALU flags.
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3Beq:   cond = zero;
            F3Bne:   cond = ~zero;
            F3Blt:   cond = s_less;
            F3Bge:   cond = ~s_less;
            F3Bltu:  cond = u_less;
            F3Bgeu:  cond = ~u_less;
            default: cond = 1'b0;
        endcase
    end

    assign branch_taken = branch & cond;

    // Trace copy of the branch outcome.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_taken_q <= 1'b0;
        end else begin
            branch_taken_q <= branch_taken;
        end
    end

endmodule

// File: tb/tb_alu_branch_unit.sv
// Self-checking bench for alu_branch_unit: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_alu_branch_unit;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [63:0] y;
        logic        z;
        logic        sl;
        logic        ul;
        logic        bt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  alu_op = 2'b00;
    logic [2:0]  funct3 = 3'b000;
    logic        funct7_b5 = 1'b0;
    logic        branch = 1'b0;
    logic [63:0] a1 = 64'd0;
    logic [63:0] a2 = 64'd0;
    logic [3:0]  alu_control;
    logic [63:0] y;
    logic        zero;
    logic        s_less;
    logic        u_less;
    logic        branch_taken;
    logic        branch_taken_q;

    int   total = 0;
    int   bad = 0;
    exp_t cur;
    logic exp_q;

    always #5 clk = ~clk;

    alu_branch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_op         (alu_op),
        .funct3         (funct3),
        .funct7_b5      (funct7_b5),
        .branch         (branch),
        .a1             (a1),
        .a2             (a2),
        .alu_control    (alu_control),
        .y              (y),
        .zero           (zero),
        .s_less         (s_less),
        .u_less         (u_less),
        .branch_taken   (branch_taken),
        .branch_taken_q (branch_taken_q)
    );

    // Behavioural model: name the operation, then compute its result arithmetically.
    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                   input logic br, input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        int          sh;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic        c;
        sa   = a;
        sb   = b;
        sh   = int'(b % 64);
        e.sl = sa < sb;
        e.ul = a < b;
        if (op == 2'b00)      e.ctl = 4'd2;
        else if (op == 2'b01) e.ctl = 4'd6;
        else begin
            case (f3)
                3'd0: e.ctl = (f7 && op == 2'b10) ? 4'd6 : 4'd2;
                3'd1: e.ctl = 4'd4;
                3'd2: e.ctl = 4'd8;
                3'd3: e.ctl = 4'd9;
                3'd4: e.ctl = 4'd3;
                3'd5: e.ctl = f7 ? 4'd7 : 4'd5;
                3'd6: e.ctl = 4'd1;
                default: e.ctl = 4'd0;
            endcase
        end
        case (e.ctl)
            4'd0: e.y = a & b;
            4'd1: e.y = a | b;
            4'd2: e.y = a + b;
            4'd3: e.y = a ^ b;
            4'd4: e.y = a << sh;
            4'd5: e.y = a >> sh;
            4'd6: e.y = a - b;
            // Arithmetic shift as logical shift with the vacated top bits filled by the sign.
            4'd7: e.y = (a >> sh) | (a[63] ? ~(~64'd0 >> sh) : 64'd0);
            4'd8: e.y = e.sl ? 64'd1 : 64'd0;
            4'd9: e.y = e.ul ? 64'd1 : 64'd0;
            default: e.y = 64'd0;
        endcase
        e.z = (e.y == 64'd0);
        case (f3)
            3'd0: c = e.z;
            3'd1: c = !e.z;
            3'd4: c = e.sl;
            3'd5: c = !e.sl;
            3'd6: c = e.ul;
            3'd7: c = !e.ul;
            default: c = 1'b0;
        endcase
        e.bt = br && c;
        return e;
    endfunction

    assign cur = model(alu_op, funct3, funct7_b5, branch, a1, a2);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_q <= 1'b0;
        else        exp_q <= cur.bt;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every falling edge: all outputs against the model.
    always @(negedge clk) begin
        chk("m_alu_control", 64'(alu_control), 64'(cur.ctl));
        chk("m_y", y, cur.y);
        chk("m_zero", 64'(zero), 64'(cur.z));
        chk("m_s_less", 64'(s_less), 64'(cur.sl));
        chk("m_u_less", 64'(u_less), 64'(cur.ul));
        chk("m_branch_taken", 64'(branch_taken), 64'(cur.bt));
        chk("m_branch_taken_q", 64'(branch_taken_q), 64'(exp_q));
    end

    task automatic apply(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic br, input logic [63:0] a, input logic [63:0] b);
        @(posedge clk);
        #2;
        alu_op    = op;
        funct3    = f3;
        funct7_b5 = f7;
        branch    = br;
        a1        = a;
        a2        = b;
        #1;
    endtask

    initial begin
        #1;
        chk("q_in_reset", 64'(branch_taken_q), 64'd0);
        #6;
        rst_n = 1'b1;

        // ADD / SUB decode
        apply(2'b10, 3'b000, 1'b0, 1'b0, 64'd5, 64'd7);
        chk("add_ctl", 64'(alu_control), 64'h2);
        chk("add_y", y, 64'd12);
        apply(2'b10, 3'b000, 1'b1, 1'b0, 64'd5, 64'd7);
        chk("sub_ctl", 64'(alu_control), 64'h6);
        chk("sub_y", y, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_zero", 64'(zero), 64'd0);
        chk("sub_sless", 64'(s_less), 64'd1);

        // I-type: funct7 bit ignored for ADD, honoured for SRA
        apply(2'b11, 3'b000, 1'b1, 1'b0, 64'd5, 64'd7);
        chk("itype_add_ctl", 64'(alu_control), 64'h2);
        chk("itype_add_y", y, 64'd12);
        apply(2'b11, 3'b101, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd4);
        chk("itype_sra_y", y, 64'hF800_0000_0000_0000);

        // Compare flags, SLT / SLTU
        apply(2'b10, 3'b011, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("sltu_y", y, 64'd0);
        chk("neg1_sless", 64'(s_less), 64'd1);
        chk("neg1_uless", 64'(u_less), 64'd0);
        apply(2'b10, 3'b010, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("slt_y", y, 64'd1);
        apply(2'b10, 3'b111, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd1);
        chk("min_sless", 64'(s_less), 64'd1);
        chk("min_uless", 64'(u_less), 64'd0);

        // ADD wrap
        apply(2'b00, 3'b010, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("wrap_y", y, 64'd0);
        chk("wrap_zero", 64'(zero), 64'd1);

        // Branch judge
        apply(2'b01, 3'b000, 1'b0, 1'b1, 64'd9, 64'd9);
        chk("beq_eq", 64'(branch_taken), 64'd1);
        chk("eq_zero", 64'(zero), 64'd1);
        chk("eq_sless", 64'(s_less), 64'd0);
        chk("eq_uless", 64'(u_less), 64'd0);
        apply(2'b01, 3'b001, 1'b0, 1'b1, 64'd9, 64'd9);
        chk("bne_eq", 64'(branch_taken), 64'd0);
        apply(2'b01, 3'b100, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("blt_neg", 64'(branch_taken), 64'd1);
        apply(2'b01, 3'b111, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("bgeu_neg", 64'(branch_taken), 64'd1);
        apply(2'b01, 3'b110, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("bltu_neg", 64'(branch_taken), 64'd0);
        apply(2'b01, 3'b101, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("bge_neg", 64'(branch_taken), 64'd0);
        apply(2'b01, 3'b010, 1'b0, 1'b1, 64'd9, 64'd9);
        chk("f3_010", 64'(branch_taken), 64'd0);
        apply(2'b01, 3'b000, 1'b0, 1'b0, 64'd9, 64'd9);
        chk("no_branch", 64'(branch_taken), 64'd0);

        // Shift bounds
        apply(2'b10, 3'b001, 1'b0, 1'b0, 64'd1, 64'h40);
        chk("sll_64", y, 64'd1);
        apply(2'b10, 3'b001, 1'b0, 1'b0, 64'd1, 64'd63);
        chk("sll_63", y, 64'h8000_0000_0000_0000);
        apply(2'b10, 3'b101, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'd63);
        chk("srl_63", y, 64'd1);

        // Registered outcome and asynchronous reset
        apply(2'b01, 3'b000, 1'b0, 1'b1, 64'd9, 64'd9);
        chk("pre_q_bt", 64'(branch_taken), 64'd1);
        @(posedge clk);
        #1;
        chk("q_after_edge", 64'(branch_taken_q), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("q_async_clear", 64'(branch_taken_q), 64'd0);
        chk("bt_in_reset", 64'(branch_taken), 64'd1);
        chk("y_in_reset", y, 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk("q_after_release", 64'(branch_taken_q), 64'd0);
        @(posedge clk);
        #1;
        chk("q_first_edge", 64'(branch_taken_q), 64'd1);

        // A not-taken branch clears the register on the next edge.
        apply(2'b01, 3'b001, 1'b0, 1'b1, 64'd9, 64'd9);
        @(posedge clk);
        #1;
        chk("q_cleared", 64'(branch_taken_q), 64'd0);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_branch_unit.md
Name: alu_branch_unit

Overview:
- Execute-stage compute block of the single-cycle RV64 core.
- Merges ALU-operation decode, the 64-bit integer ALU with comparison flags, and the conditional-branch decision.
- All results are combinational, so the same-cycle next-PC mux and the data-memory address can use them.
- One registered status bit, last-cycle branch outcome, is available for debug/trace.

Parameters:
- XLEN, 64, datapath width.
- SHAMT_W, 6, number of low operand-B bits used as the shift amount.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- alu_op  in  2  class from main control: 00 load/store, 01 branch, 10 R-type, 11 I-type ALU.
- funct3  in  3  instruction bits [14:12].
- funct7_b5  in  1  instruction bit [30].
- branch  in  1  instruction is a conditional branch.
- a1  in  XLEN  operand A (rs1).
- a2  in  XLEN  operand B (rs2 or immediate).
- alu_control  out  4  decoded operation code.
- y  out  XLEN  result.
- zero  out  1  y == 0.
- s_less  out  1  signed a1 < a2.
- u_less  out  1  unsigned a1 < a2.
- branch_taken  out  1  conditional branch resolves taken.
- branch_taken_q  out  1  branch_taken registered on the rising clock edge.

Behaviour:
- alu_control encoding: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 0110 SUB, 0111 SRA, 1000 SLT, 1001 SLTU. Unlisted codes give y = 0.
- Decode, alu_op 00 → ADD.
- Decode, alu_op 01 → SUB.
- Decode, alu_op 10 → by funct3:
  - 000: SUB if funct7_b5, else ADD.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101: SRA if funct7_b5, else SRL.
  - 110 OR, 111 AND.
- Decode, alu_op 11 → same as 10, except funct3 000 is always ADD (funct7_b5 ignored, since the immediate sits in those bits). funct3 101 still uses funct7_b5.
- Arithmetic is modulo 2^XLEN; no overflow flag.
- Shifts use a2[SHAMT_W-1:0] only. SRA replicates a1[63].
- SLT and SLTU give 64'd1 or 64'd0.
- zero is derived from y.
- s_less and u_less are always computed from a1 and a2, independent of the selected operation.
- branch_taken = branch AND condition. Condition by funct3:
  - 000 zero, 001 !zero.
  - 100 s_less, 101 !s_less.
  - 110 u_less, 111 !u_less.
  - 010 and 011 → 0.
- branch = 0 → branch_taken = 0 regardless of the other inputs.
- Every output except branch_taken_q is purely combinational, with zero latency and no handshake.
- branch_taken_q:
  - 0 while rst_n is low; asserting reset clears it immediately, without waiting for a clock edge.
  - After reset deasserts, updates on every rising clk edge.
  - Reset does not affect any combinational output.
- Boundary cases:
  - a1 = a2 → zero = 1 under SUB; s_less = u_less = 0.
  - a1 = 0x8000_0000_0000_0000, a2 = 1 → s_less = 1, u_less = 0.
  - ADD of 0xFFFF_FFFF_FFFF_FFFF + 1 → y = 0, zero = 1.
  - Shift amount 63 is legal. a2 bits above SHAMT_W are ignored.

Decomposition:
- Shared package alu_pkg:
  - alu_op class constants.
  - the 4-bit alu_control operation constants.
  - branch funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU).
  - XLEN.
- One natural sub-module, alu_core: operation select plus flags. Decode, branch judge and the status register stay in the top level.

Test Plan:
- ADD/SUB decode: alu_op 10, funct3 000, funct7_b5 0, a1 = 5, a2 = 7 → alu_control 0010, y = 12. With funct7_b5 1 → alu_control 0110, y = 0xFFFF_FFFF_FFFF_FFFE, zero = 0, s_less = 1.
- I-type funct7 quirk: alu_op 11, funct3 000, funct7_b5 1 → ADD. alu_op 11, funct3 101, funct7_b5 1, a1 = 0x8000_0000_0000_0000, a2 = 4 → y = 0xF800_0000_0000_0000.
- Compare flags: a1 = 0xFFFF_FFFF_FFFF_FFFF, a2 = 1 → s_less = 1, u_less = 0. SLTU gives y = 0, SLT gives y = 1.
- Branch judge, alu_op 01, branch 1:
  - a1 = a2 = 9 → BEQ taken, BNE not taken.
  - a1 = −1, a2 = 1 → BLT taken, BGEU taken, BLTU not taken.
  - funct3 010 → not taken.
  - branch 0 with BEQ and equal operands → not taken.
- Shift bounds: SLL with a1 = 1, a2 = 0x40 → y = 1 (shift amount 0). a2 = 63 → y = 0x8000_0000_0000_0000.
- Reset and register:
  - Drive a taken BEQ and clock → branch_taken_q = 1.
  - Drop rst_n mid-cycle → branch_taken_q = 0 immediately while branch_taken stays 1.
  - Release reset → branch_taken_q = 1 on the next rising edge.
